idmem_loader: RTL

- Initiator-side master for the IDMem instruction/data memory port (We/addr/Wd write, dout combinational read).
- Streams a program image from a valid/ready word source into consecutive memory words, then reads the region back and checks a 32-bit additive checksum.
- Sits between the host/boot path and IDMem in the multicycle processor. It owns the memory port only while busy; the processor muxes it out otherwise.

---
 rtl/idmem_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/idmem_loader.sv
// rtl/idmem_loader.sv - streams a word image into IDMem, reads it back and compares additive checksums
module idmem_loader #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] count,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] load_sum_q, load_sum_d;
    logic [DW-1:0] vfy_sum_q, vfy_sum_d;
    logic          pass_q, pass_d;
    logic [DW-1:0] checksum_q, checksum_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            base_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            load_sum_q <= '0;
            vfy_sum_q  <= '0;
            pass_q     <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            load_sum_q <= load_sum_d;
            vfy_sum_q  <= vfy_sum_d;
            pass_q     <= pass_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        base_d     = base_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        load_sum_d = load_sum_q;
        vfy_sum_d  = vfy_sum_q;
        pass_d     = pass_q;
        checksum_d = checksum_q;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = ptr_q;
        mem_wd     = '0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_sum_d = '0;
                    vfy_sum_d  = '0;
                    if (count != '0) begin
                        ptr_d   = base_addr;
                        base_d  = base_addr;
                        rem_d   = count;
                        cnt_d   = count;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                mem_wd   = in_data;
                mem_we   = in_valid;
                if (in_valid) begin
                    load_sum_d = load_sum_q + in_data;
                    // Rewind to the region start so VERIFY walks the same words.
                    if (rem_q == CW'(1)) begin
                        ptr_d   = base_q;
                        rem_d   = cnt_q;
                        state_d = S_VERIFY;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                        rem_d = rem_q - CW'(1);
                    end
                end
            end
            S_VERIFY: begin
                busy      = 1'b1;
                vfy_sum_d = vfy_sum_q + mem_dout;
                ptr_d     = ptr_q + AW'(1);
                rem_d     = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                done       = 1'b1;
                pass_d     = (load_sum_q == vfy_sum_q);
                checksum_d = load_sum_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pass     = pass_q;
    assign checksum = checksum_q;

endmodule
